// File: rtl/ps2_key_tracker.sv
// ---------------------------------------------------------------------------
// ps2_key_tracker
//
// Turns the PS/2 byte stream into key events and Pong control state.
//
// Make, break and extended scan-code sequences are assembled by a small FSM.
// A completed sequence produces one evt_* event. It also updates held flags
// for W/S (player 1) and Up/Down arrows (player 2). The held flags give the
// paddle direction codes. Fresh presses of Space and Esc produce one-cycle
// serve/pause pulses. If a prefix byte is left waiting too long, the
// sequence is abandoned.
//
// Ports:
//   inclock       system clock
//   reset         synchronous, active-high reset
//   key_data      received scan-code byte, valid while key_pressed=1
//   key_pressed   one-cycle strobe per received byte
//   p1_up_held    W (1D) held
//   p1_down_held  S (1B) held
//   p2_up_held    Up arrow (E0 75) held
//   p2_down_held  Down arrow (E0 72) held
//   p1_dir        01=up, 10=down, 00=none or both
//   p2_dir        same encoding for player 2
//   serve_pulse   one cycle on a fresh press of Space (29)
//   pause_pulse   one cycle on a fresh press of Esc (76)
//   evt_valid     one cycle per completed make/break sequence
//   evt_code      final byte of the last sequence
//   evt_ext       last sequence carried the E0 prefix
//   evt_break     last sequence carried the F0 prefix
// ---------------------------------------------------------------------------
module ps2_key_tracker #(
   parameter int TIMEOUT_CYCLES = 2500000
) (
   input  logic       inclock,
   input  logic       reset,
   input  logic [7:0] key_data,
   input  logic       key_pressed,
   output logic       p1_up_held,
   output logic       p1_down_held,
   output logic       p2_up_held,
   output logic       p2_down_held,
   output logic [1:0] p1_dir,
   output logic [1:0] p2_dir,
   output logic       serve_pulse,
   output logic       pause_pulse,
   output logic       evt_valid,
   output logic [7:0] evt_code,
   output logic       evt_ext,
   output logic       evt_break
);

   localparam logic [7:0] CODE_EXT   = 8'hE0;
   localparam logic [7:0] CODE_BRK   = 8'hF0;
   localparam logic [7:0] CODE_W     = 8'h1D;
   localparam logic [7:0] CODE_S     = 8'h1B;
   localparam logic [7:0] CODE_UP    = 8'h75;
   localparam logic [7:0] CODE_DOWN  = 8'h72;
   localparam logic [7:0] CODE_SPACE = 8'h29;
   localparam logic [7:0] CODE_ESC   = 8'h76;

   localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXT,
      S_BRK,
      S_EXT_BRK
   } state_t;

   state_t        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;

   logic p1_up_q, p1_up_d;
   logic p1_down_q, p1_down_d;
   logic p2_up_q, p2_up_d;
   logic p2_down_q, p2_down_d;
   logic space_q, space_d;
   logic esc_q, esc_d;

   logic       serve_q, serve_d;
   logic       pause_q, pause_d;
   logic       evt_valid_q, evt_valid_d;
   logic [7:0] evt_code_q, evt_code_d;
   logic       evt_ext_q, evt_ext_d;
   logic       evt_break_q, evt_break_d;

   // Set for one cycle when the current byte ends a sequence.
   logic done;
   logic done_ext;
   logic done_brk;
   logic is_make;

   // NOTE: every signal written here gets a default first, so there is no
   // path that leaves one unassigned. That is what keeps this block free of
   // inferred latches.
   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      p1_up_d     = p1_up_q;
      p1_down_d   = p1_down_q;
      p2_up_d     = p2_up_q;
      p2_down_d   = p2_down_q;
      space_d     = space_q;
      esc_d       = esc_q;
      serve_d     = 1'b0;
      pause_d     = 1'b0;
      evt_valid_d = 1'b0;
      evt_code_d  = evt_code_q;
      evt_ext_d   = evt_ext_q;
      evt_break_d = evt_break_q;
      done        = 1'b0;
      done_ext    = 1'b0;
      done_brk    = 1'b0;
      is_make     = 1'b0;

      if (key_pressed) begin
         timer_d = '0;
         unique case (state_q)
            S_IDLE: begin
               if (key_data == CODE_EXT)      state_d = S_EXT;
               else if (key_data == CODE_BRK) state_d = S_BRK;
               else                           done    = 1'b1;
            end
            S_EXT: begin
               if (key_data == CODE_BRK) state_d = S_EXT_BRK;
               else if (key_data != CODE_EXT) begin
                  done     = 1'b1;
                  done_ext = 1'b1;
               end
            end
            S_BRK: begin
               if (key_data == CODE_EXT) state_d = S_EXT_BRK;
               else if (key_data != CODE_BRK) begin
                  done     = 1'b1;
                  done_brk = 1'b1;
               end
            end
            S_EXT_BRK: begin
               if (key_data != CODE_EXT && key_data != CODE_BRK) begin
                  done     = 1'b1;
                  done_ext = 1'b1;
                  done_brk = 1'b1;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end else if (state_q != S_IDLE) begin
         // A prefix that waits too long is dropped silently.
         if (timer_q == TIMER_LAST) begin
            state_d = S_IDLE;
            timer_d = '0;
         end else begin
            timer_d = timer_q + TW'(1);
         end
      end else begin
         timer_d = '0;
      end

      if (done) begin
         state_d     = S_IDLE;
         evt_valid_d = 1'b1;
         evt_code_d  = key_data;
         evt_ext_d   = done_ext;
         evt_break_d = done_brk;
         is_make     = ~done_brk;

         // A make sets the flag and a break clears it. A break of a key
         // that is not held writes 0 over a 0, so nothing changes. The ext
         // bit must match, so keypad codes do not move the arrow flags.
         if (!done_ext && key_data == CODE_W)    p1_up_d   = is_make;
         if (!done_ext && key_data == CODE_S)    p1_down_d = is_make;
         if (done_ext && key_data == CODE_UP)    p2_up_d   = is_make;
         if (done_ext && key_data == CODE_DOWN)  p2_down_d = is_make;
         if (!done_ext && key_data == CODE_SPACE) begin
            // Typematic repeats find the flag already set and do not pulse.
            serve_d = is_make & ~space_q;
            space_d = is_make;
         end
         if (!done_ext && key_data == CODE_ESC) begin
            pause_d = is_make & ~esc_q;
            esc_d   = is_make;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only. Every flop
   // then samples its pre-edge inputs, whatever order the blocks run in.
   always_ff @(posedge inclock) begin
      if (reset) begin
         state_q     <= S_IDLE;
         timer_q     <= '0;
         p1_up_q     <= 1'b0;
         p1_down_q   <= 1'b0;
         p2_up_q     <= 1'b0;
         p2_down_q   <= 1'b0;
         space_q     <= 1'b0;
         esc_q       <= 1'b0;
         serve_q     <= 1'b0;
         pause_q     <= 1'b0;
         evt_valid_q <= 1'b0;
         evt_code_q  <= 8'h00;
         evt_ext_q   <= 1'b0;
         evt_break_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         p1_up_q     <= p1_up_d;
         p1_down_q   <= p1_down_d;
         p2_up_q     <= p2_up_d;
         p2_down_q   <= p2_down_d;
         space_q     <= space_d;
         esc_q       <= esc_d;
         serve_q     <= serve_d;
         pause_q     <= pause_d;
         evt_valid_q <= evt_valid_d;
         evt_code_q  <= evt_code_d;
         evt_ext_q   <= evt_ext_d;
         evt_break_q <= evt_break_d;
      end
   end

   assign p1_up_held   = p1_up_q;
   assign p1_down_held = p1_down_q;
   assign p2_up_held   = p2_up_q;
   assign p2_down_held = p2_down_q;

   // When both directions are held they cancel, giving 00.
   assign p1_dir = {p1_down_q & ~p1_up_q, p1_up_q & ~p1_down_q};
   assign p2_dir = {p2_down_q & ~p2_up_q, p2_up_q & ~p2_down_q};

   assign serve_pulse = serve_q;
   assign pause_pulse = pause_q;
   assign evt_valid   = evt_valid_q;
   assign evt_code    = evt_code_q;
   assign evt_ext     = evt_ext_q;
   assign evt_break   = evt_break_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// ---------------------------------------------------------------------------
// tb_ps2_key_tracker
//
// Drives directed and random scan-code streams into ps2_key_tracker.
//
// A reference model turns each completed sequence into an expected event.
// The model keeps the pending prefix as flags plus a count of idle cycles.
// Each expected event is pushed into a queue. A monitor pops the queue
// whenever evt_valid is seen and compares the event. Between events it
// checks that held flags, evt_* fields and pulses stay unchanged.
// ---------------------------------------------------------------------------
module tb_ps2_key_tracker;

   localparam int T = 16;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] key_data;
   logic       key_pressed;
   logic       p1_up_held, p1_down_held, p2_up_held, p2_down_held;
   logic [1:0] p1_dir, p2_dir;
   logic       serve_pulse, pause_pulse;
   logic       evt_valid;
   logic [7:0] evt_code;
   logic       evt_ext, evt_break;

   ps2_key_tracker #(.TIMEOUT_CYCLES(T)) dut (
      .inclock      (clk),
      .reset        (reset),
      .key_data     (key_data),
      .key_pressed  (key_pressed),
      .p1_up_held   (p1_up_held),
      .p1_down_held (p1_down_held),
      .p2_up_held   (p2_up_held),
      .p2_down_held (p2_down_held),
      .p1_dir       (p1_dir),
      .p2_dir       (p2_dir),
      .serve_pulse  (serve_pulse),
      .pause_pulse  (pause_pulse),
      .evt_valid    (evt_valid),
      .evt_code     (evt_code),
      .evt_ext      (evt_ext),
      .evt_break    (evt_break)
   );

   always #5 clk = ~clk;

   // held bit order: [3]=p1 up, [2]=p1 down, [1]=p2 up, [0]=p2 down
   typedef struct {
      logic [7:0] code;
      logic       ext;
      logic       brk;
      logic [3:0] held;
      logic       serve;
      logic       pause;
   } exp_t;

   exp_t exp_q[$];

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   bit         m_pending, m_ext, m_brk;
   int         m_idle;
   logic [3:0] m_held;
   bit         m_space, m_esc;

   task automatic model_reset();
      m_pending = 0; m_ext = 0; m_brk = 0; m_idle = 0;
      m_held = 4'b0000; m_space = 0; m_esc = 0;
   endtask

   task automatic model_idle();
      m_idle++;
      if (m_pending && m_idle >= T) begin
         m_pending = 0; m_ext = 0; m_brk = 0;
      end
   endtask

   task automatic model_byte(input logic [7:0] b);
      exp_t e;
      bit   mk;
      m_idle = 0;
      if (b == 8'hE0) begin
         m_pending = 1; m_ext = 1;
      end else if (b == 8'hF0) begin
         m_pending = 1; m_brk = 1;
      end else begin
         mk = !m_brk;
         e.code = b; e.ext = m_ext; e.brk = m_brk;
         e.serve = 0; e.pause = 0;
         if (!m_ext) begin
            case (b)
               8'h1D: m_held[3] = mk;
               8'h1B: m_held[2] = mk;
               8'h29: begin e.serve = mk && !m_space; m_space = mk; end
               8'h76: begin e.pause = mk && !m_esc;   m_esc   = mk; end
               default: ;
            endcase
         end else begin
            case (b)
               8'h75: m_held[1] = mk;
               8'h72: m_held[0] = mk;
               default: ;
            endcase
         end
         e.held = m_held;
         exp_q.push_back(e);
         m_pending = 0; m_ext = 0; m_brk = 0;
      end
   endtask

   function automatic logic [1:0] dir_of(input bit up, input bit down);
      if (up && !down) return 2'b01;
      if (down && !up) return 2'b10;
      return 2'b00;
   endfunction

   // ---------------- monitor ----------------
   logic [3:0] mon_held = 4'b0000;
   logic [7:0] mon_code = 8'h00;
   logic       mon_ext = 1'b0, mon_brk = 1'b0;
   bit         mon_on = 0;

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (mon_on) begin
            if (evt_valid) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_evt", {24'h0, evt_code}, 32'hFFFF_FFFF);
               end else begin
                  e = exp_q.pop_front();
                  check("evt_code", evt_code, e.code);
                  check("evt_ext", evt_ext, e.ext);
                  check("evt_break", evt_break, e.brk);
                  check("serve_pulse", serve_pulse, e.serve);
                  check("pause_pulse", pause_pulse, e.pause);
                  mon_held = e.held; mon_code = e.code;
                  mon_ext = e.ext; mon_brk = e.brk;
               end
            end else begin
               check("idle_serve", serve_pulse, 0);
               check("idle_pause", pause_pulse, 0);
               check("hold_code", evt_code, mon_code);
               check("hold_ext", evt_ext, mon_ext);
               check("hold_break", evt_break, mon_brk);
            end
            check("held", {p1_up_held, p1_down_held, p2_up_held, p2_down_held}, mon_held);
            check("p1_dir", p1_dir, dir_of(mon_held[3], mon_held[2]));
            check("p2_dir", p2_dir, dir_of(mon_held[1], mon_held[0]));
         end
      end
   end

   // ---------------- driver ----------------
   task automatic idle_cycle();
      key_pressed = 0;
      model_idle();
      @(posedge clk); #1;
   endtask

   task automatic send(input logic [7:0] b, input int gap);
      repeat (gap) idle_cycle();
      key_data = b;
      key_pressed = 1;
      model_byte(b);
      @(posedge clk); #1;
      key_pressed = 0;
   endtask

   task automatic do_reset(input bit with_strobe);
      reset = 1;
      key_pressed = with_strobe;
      key_data = 8'h1D;
      @(posedge clk); #1;
      reset = 0;
      key_pressed = 0;
      model_reset();
      mon_held = 4'b0000; mon_code = 8'h00; mon_ext = 0; mon_brk = 0;
      @(negedge clk);
      check("rst_held", {p1_up_held, p1_down_held, p2_up_held, p2_down_held}, 0);
      check("rst_dir", {p1_dir, p2_dir}, 0);
      check("rst_pulses", {serve_pulse, pause_pulse}, 0);
      check("rst_evt", {evt_valid, evt_code, evt_ext, evt_break}, 0);
      @(posedge clk); #1;
      model_idle();
   endtask

   logic [7:0] pool [8] = '{8'h1D, 8'h1B, 8'h75, 8'h72, 8'h29, 8'h76, 8'hE0, 8'hF0};

   initial begin
      int gap;
      logic [7:0] b;
      reset = 1; key_pressed = 0; key_data = 8'h00;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      do_reset(0);
      mon_on = 1;

      // W press and release
      send(8'h1D, 0);
      send(8'hF0, 40);
      send(8'h1D, 0);
      // Down arrow press/release, then bare 72
      send(8'hE0, 3); send(8'h72, 0);
      send(8'hE0, 3); send(8'hF0, 0); send(8'h72, 0);
      send(8'h72, 3);
      // Space typematic
      repeat (5) send(8'h29, 2);
      send(8'hF0, 2); send(8'h29, 0);
      send(8'h29, 2);
      // Both directions for player 1
      send(8'h1D, 2); send(8'h1B, 2);
      send(8'hF0, 2); send(8'h1D, 0);
      // Timeout inside a prefix
      send(8'hE0, 2); send(8'h75, 20);
      // Timeout boundary: just inside and just past
      send(8'hE0, 2); send(8'h75, T - 1);
      send(8'hE0, 2); send(8'hF0, T); send(8'h75, 0);
      // Esc
      send(8'h76, 2); send(8'h76, 1); send(8'hF0, 1); send(8'h76, 0);
      // Reset mid-prefix, then 1D is a make
      send(8'hF0, 2);
      do_reset(0);
      send(8'h1D, 0);
      // Reset wins over a simultaneous strobe
      send(8'hE0, 2);
      do_reset(1);
      send(8'h72, 1);

      // Random stream
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 9) < 8) b = pool[$urandom_range(0, 7)];
         else b = 8'($urandom_range(0, 255));
         case ($urandom_range(0, 9))
            0:       gap = $urandom_range(T - 2, T + 1);
            1, 2:    gap = $urandom_range(4, 10);
            default: gap = $urandom_range(0, 2);
         endcase
         send(b, gap);
      end

      repeat (5) idle_cycle();
      check("queue_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   // Overall time bound.
   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
